// File: rtl/led_mode_sequencer_pkg.sv
// Shared definitions for the LED mode sequencer: controller states, mode
// constants and the modulo-4 mode successor.
package led_mode_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_MANUAL = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSE  = 2'd2,
      ST_SWITCH = 2'd3
   } seq_state_e;

   localparam logic [1:0] MODE_0 = 2'd0;
   localparam logic [1:0] MODE_1 = 2'd1;
   localparam logic [1:0] MODE_2 = 2'd2;
   localparam logic [1:0] MODE_3 = 2'd3;

   function automatic logic [1:0] mode_succ(input logic [1:0] m);
      return m + 2'd1;
   endfunction

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// Push-button conditioner: synchronises the raw button, requires DEB_CYC stable
// samples before accepting a new level, and pulses press on each accepted rise.
module btn_debounce
   import led_mode_sequencer_pkg::*;
#(
   parameter int DEB_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEB_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          meta_r;
   logic          sync_r;
   logic          level_r;
   logic          level_d_r;
   logic          press_r;
   logic [CW-1:0] cnt_r;

   // Synchroniser, stability counter and rising-edge pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r    <= 1'b0;
         sync_r    <= 1'b0;
         level_r   <= 1'b0;
         level_d_r <= 1'b0;
         press_r   <= 1'b0;
         cnt_r     <= '0;
      end else begin
         meta_r    <= btn;
         sync_r    <= meta_r;
         level_d_r <= level_r;
         press_r   <= level_r & ~level_d_r;
         if (sync_r == level_r) begin
            cnt_r <= '0;
         end else if (cnt_r == CNT_LAST) begin
            level_r <= sync_r;
            cnt_r   <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign press = press_r;

endmodule

// File: rtl/led_mode_sequencer.sv
// Mode controller for the 4-mode LED pattern engine: clock-enable tick, manual
// or automatic mode selection with dwell-based rotation, and button pause.
module led_mode_sequencer
   import led_mode_sequencer_pkg::*;
#(
   parameter int CLK_DIV = 25_000_000,
   parameter int DWELL   = 16,
   parameter int DEB_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       auto_en,
   input  logic [1:0] sel_in,
   input  logic       btn,
   output logic       tick,
   output logic [1:0] mode,
   output logic       mode_load,
   output logic       paused
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int DW = $clog2(DWELL + 1);
   localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PRE_ONE    = PW'(1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

   logic          auto_meta_r, auto_sync_r;
   logic [1:0]    sel_meta_r, sel_sync_r;
   logic          press_s;

   seq_state_e    state_r, nxt_state_s;
   logic [1:0]    mode_r, nxt_mode_s;
   logic          tick_r, tick_nxt_s;
   logic          mode_load_r, paused_r;
   logic [PW-1:0] pre_r, pre_nxt_s;
   logic [DW-1:0] dwell_r, dwell_nxt_s;

   btn_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .press (press_s)
   );

   // Two-stage synchronisers for the switch inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         auto_meta_r <= 1'b0;
         auto_sync_r <= 1'b0;
         sel_meta_r  <= 2'b00;
         sel_sync_r  <= 2'b00;
      end else begin
         auto_meta_r <= auto_en;
         auto_sync_r <= auto_meta_r;
         sel_meta_r  <= sel_in;
         sel_sync_r  <= sel_meta_r;
      end
   end

   // Next state, next mode, dwell and prescaler; outputs are registered from these.
   always_comb begin
      nxt_state_s = state_r;
      nxt_mode_s  = mode_r;
      dwell_nxt_s = dwell_r;
      pre_nxt_s   = pre_r;
      case (state_r)
         ST_MANUAL: begin
            if (sel_sync_r != mode_r) begin
               nxt_state_s = ST_SWITCH;
               nxt_mode_s  = sel_sync_r;
            end else if (auto_sync_r) begin
               nxt_state_s = ST_RUN;
            end else begin
               nxt_state_s = ST_MANUAL;
            end
         end
         ST_RUN: begin
            if (!auto_sync_r) begin
               nxt_state_s = ST_SWITCH;
               nxt_mode_s  = sel_sync_r;
            end else if (press_s) begin
               nxt_state_s = ST_PAUSE;
            end else if (tick_r) begin
               if (dwell_r == DWELL_LAST) begin
                  nxt_state_s = ST_SWITCH;
                  nxt_mode_s  = mode_succ(mode_r);
               end else begin
                  dwell_nxt_s = dwell_r + DWELL_ONE;
               end
            end else begin
               nxt_state_s = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (!auto_sync_r) begin
               nxt_state_s = ST_SWITCH;
               nxt_mode_s  = sel_sync_r;
            end else if (press_s) begin
               nxt_state_s = ST_RUN;
            end else begin
               nxt_state_s = ST_PAUSE;
            end
         end
         ST_SWITCH: begin
            if (auto_sync_r) begin
               nxt_state_s = ST_RUN;
            end else begin
               nxt_state_s = ST_MANUAL;
            end
         end
         default: begin
            nxt_state_s = ST_MANUAL;
         end
      endcase

      // The SWITCH cycle and the cycle after it both see a zero count.
      if ((nxt_state_s == ST_SWITCH) || (state_r == ST_SWITCH)) begin
         dwell_nxt_s = '0;
         pre_nxt_s   = '0;
      end else if (state_r == ST_PAUSE) begin
         pre_nxt_s = pre_r;
      end else if (pre_r == PRE_LAST) begin
         pre_nxt_s = '0;
      end else begin
         pre_nxt_s = pre_r + PRE_ONE;
      end

      tick_nxt_s = ((nxt_state_s == ST_RUN) || (nxt_state_s == ST_MANUAL)) &&
                   (pre_nxt_s == PRE_LAST);
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_MANUAL;
         mode_r      <= MODE_0;
         tick_r      <= 1'b0;
         mode_load_r <= 1'b0;
         paused_r    <= 1'b0;
         pre_r       <= '0;
         dwell_r     <= '0;
      end else begin
         state_r     <= nxt_state_s;
         mode_r      <= nxt_mode_s;
         tick_r      <= tick_nxt_s;
         mode_load_r <= (nxt_state_s == ST_SWITCH);
         paused_r    <= (nxt_state_s == ST_PAUSE);
         pre_r       <= pre_nxt_s;
         dwell_r     <= dwell_nxt_s;
      end
   end

   assign tick      = tick_r;
   assign mode      = mode_r;
   assign mode_load = mode_load_r;
   assign paused    = paused_r;

endmodule
